// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum band aggregator and the display driver it feeds.
// Holds the FFT-bin to display-band map and the 96-bit packed spectrum word type.
package spectrum_pkg;

  localparam int unsigned N_BANDS    = 8;
  localparam int unsigned BAND_W     = 12;
  localparam int unsigned BAND_IDX_W = 3;
  localparam int unsigned MAX_BIN    = 63;

  // Inclusive upper bin of each band; band k starts one past BAND_HI[k-1].
  localparam int unsigned BAND_HI [N_BANDS] = '{1, 2, 4, 8, 12, 20, 36, 63};

  typedef logic [N_BANDS*BAND_W-1:0] spectrum_packed_t;

  typedef struct packed {
    logic                  valid;
    logic [BAND_IDX_W-1:0] band;
  } band_sel_t;

  typedef enum logic [1:0] {
    StAccum,
    StFinal,
    StPublish
  } agg_state_e;

  function automatic band_sel_t bin_to_band(input int unsigned bin);
    band_sel_t r;
    r.valid = (bin >= 1) && (bin <= MAX_BIN);
    r.band  = '0;
    for (int k = int'(N_BANDS) - 1; k >= 0; k--) begin
      if (bin <= BAND_HI[k]) r.band = BAND_IDX_W'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/band_scaler.sv
// Combinational per-band output stage: shift, saturate to 12 bits, and (PEAK_HOLD_EN)
// merge with the decayed held value.
module band_scaler
  import spectrum_pkg::*;
#(
  parameter int unsigned MAG_W     = 16,
  parameter int unsigned MAG_SHIFT = 4
`ifdef PEAK_HOLD_EN
  ,
  parameter logic [BAND_W-1:0] DECAY = 12'd64
`endif
) (
  input  logic [MAG_W-1:0]  peak,
`ifdef PEAK_HOLD_EN
  input  logic [BAND_W-1:0] held,
`endif
  output logic [BAND_W-1:0] band_out
);

  localparam int unsigned BAND_MAX = (1 << BAND_W) - 1;

  logic [MAG_W-1:0]  shifted;
  logic [BAND_W-1:0] scaled;

  always_comb begin
    shifted = peak >> MAG_SHIFT;
    scaled  = (32'(shifted) > BAND_MAX) ? BAND_W'(BAND_MAX) : shifted[BAND_W-1:0];
  end

`ifdef PEAK_HOLD_EN
  logic [BAND_W-1:0] decayed;

  always_comb begin
    decayed  = (held > DECAY) ? (held - DECAY) : '0;
    band_out = (scaled > decayed) ? scaled : decayed;
  end
`else
  assign band_out = scaled;
`endif

endmodule

// File: rtl/spectrum_band_aggregator.sv
// Reduces one streamed frame of FFT magnitude bins to 8 saturated 12-bit display bands.
// Define PEAK_HOLD_EN to add per-band peak hold with a fixed per-frame decay.
module spectrum_band_aggregator
  import spectrum_pkg::*;
#(
  parameter int unsigned N_BINS    = 64,
  parameter int unsigned MAG_W     = 16,
  parameter int unsigned MAG_SHIFT = 4
`ifdef PEAK_HOLD_EN
  ,
  parameter logic [BAND_W-1:0] DECAY = 12'd64
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MAG_W-1:0]            mag_data,
  input  logic                        mag_valid,
  input  logic                        mag_last,
  output logic                        mag_ready,
  output logic [N_BANDS*BAND_W-1:0]   spectrum_data_packed,
  output logic                        spectrum_valid,
  output logic                        frame_overrun
);

  localparam int unsigned CNT_W = $clog2(N_BINS + 1);

  agg_state_e              state_q, state_d;
  logic [BAND_IDX_W-1:0]   fin_idx_q, fin_idx_d;
  logic [CNT_W-1:0]        bin_cnt_q;
  logic [MAG_W-1:0]        peak_q [N_BANDS];
  spectrum_packed_t        stage_q, stage_d, out_q;
  logic                    overrun_q;
  logic                    accept;
  logic                    in_range;
  logic                    fin_last;
  band_sel_t               sel;
  logic [BAND_W-1:0]       band_val;

  assign mag_ready            = (state_q == StAccum);
  assign spectrum_valid       = (state_q == StPublish);
  assign spectrum_data_packed = out_q;
  assign frame_overrun        = overrun_q;

  assign accept   = mag_valid && mag_ready;
  assign in_range = 32'(bin_cnt_q) < N_BINS;
  assign sel      = bin_to_band(32'(bin_cnt_q));
  assign fin_last = (fin_idx_q == BAND_IDX_W'(N_BANDS - 1));

`ifdef PEAK_HOLD_EN
  logic [BAND_W-1:0] held_q [N_BANDS];
`endif

  // One scaler shared by all bands; FINALIZE walks it across band 0..7.
  band_scaler #(
    .MAG_W    (MAG_W),
`ifdef PEAK_HOLD_EN
    .DECAY    (DECAY),
`endif
    .MAG_SHIFT(MAG_SHIFT)
  ) u_scaler (
    .peak    (peak_q[fin_idx_q]),
`ifdef PEAK_HOLD_EN
    .held    (held_q[fin_idx_q]),
`endif
    .band_out(band_val)
  );

  always_comb begin
    state_d   = state_q;
    fin_idx_d = fin_idx_q;
    unique case (state_q)
      StAccum: begin
        if (accept && mag_last) begin
          state_d   = StFinal;
          fin_idx_d = '0;
        end
      end
      StFinal: begin
        fin_idx_d = fin_idx_q + 1'b1;
        if (fin_last) state_d = StPublish;
      end
      StPublish: state_d = StAccum;
      default:   state_d = StAccum;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    stage_d[32'(fin_idx_q)*BAND_W +: BAND_W] = band_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAccum;
      fin_idx_q <= '0;
      bin_cnt_q <= '0;
      overrun_q <= 1'b0;
      stage_q   <= '0;
      out_q     <= '0;
      for (int k = 0; k < int'(N_BANDS); k++) peak_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      fin_idx_q <= fin_idx_d;
      overrun_q <= accept && !in_range;
      if (accept) begin
        if (mag_last) begin
          bin_cnt_q <= '0;
        end else if (in_range) begin
          bin_cnt_q <= bin_cnt_q + 1'b1;
        end
        if (in_range && sel.valid && (mag_data > peak_q[sel.band])) begin
          peak_q[sel.band] <= mag_data;
        end
      end
      if (state_q == StFinal) begin
        peak_q[fin_idx_q] <= '0;
        stage_q           <= stage_d;
        // Whole word moves at once so downstream never sees a half-built frame.
        if (fin_last) out_q <= stage_d;
      end
    end
  end

`ifdef PEAK_HOLD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_BANDS); k++) held_q[k] <= '0;
    end else if (state_q == StFinal) begin
      held_q[fin_idx_q] <= band_val;
    end
  end
`endif

endmodule

// File: tb/tb_spectrum_band_aggregator.sv
// Randomized self-checking bench for spectrum_band_aggregator against a frame-level model.
// Honours PEAK_HOLD_EN to match the build under test.
module tb_spectrum_band_aggregator;

  localparam int N_BINS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mag_data;
  logic        mag_valid;
  logic        mag_last;
  logic        mag_ready;
  logic [95:0] spectrum_data_packed;
  logic        spectrum_valid;
  logic        frame_overrun;

  spectrum_band_aggregator u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mag_data            (mag_data),
    .mag_valid           (mag_valid),
    .mag_last            (mag_last),
    .mag_ready           (mag_ready),
    .spectrum_data_packed(spectrum_data_packed),
    .spectrum_valid      (spectrum_valid),
    .frame_overrun       (frame_overrun)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [95:0] exp_q [$];
  int          len_q [$];
  int          frame_bins [128];
  logic [95:0] last_pub = '0;
  int          ovr_cnt = 0;
  int          ovr_exp = 0;
  int          beat_cnt = 0;
  bit          ready_watch = 1'b0;
  int          low_cnt = 0;
  int          last_cyc = 0;
`ifdef PEAK_HOLD_EN
  int          held_m [8] = '{default: 0};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int band_of(input int b);
    if (b == 1) return 0;
    if (b == 2) return 1;
    if (b <= 4) return 2;
    if (b <= 8) return 3;
    if (b <= 12) return 4;
    if (b <= 20) return 5;
    if (b <= 36) return 6;
    return 7;
  endfunction

  function automatic int rand_mag();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535));
    return int'($urandom_range(0, 8191));
  endfunction

  // Monitor: publish contents, latency, hold-between-frames, beat count, ready gap.
  always @(negedge clk) begin
    if (!rst_n) begin
      ready_watch = 1'b0;
      beat_cnt    = 0;
      last_pub    = '0;
      check("rst_data", spectrum_data_packed, '0);
    end else begin
      if (frame_overrun) ovr_cnt++;
      if (ready_watch) begin
        if (!mag_ready) low_cnt++;
        else begin
          check("ready_low_cycles", low_cnt, 9);
          ready_watch = 1'b0;
        end
      end
      if (mag_valid && mag_ready) begin
        beat_cnt++;
        if (mag_last) begin
          if (len_q.size() == 0) check("unexpected_last", 1, 0);
          else check("beats_per_frame", beat_cnt, len_q.pop_front());
          beat_cnt    = 0;
          ready_watch = 1'b1;
          low_cnt     = 0;
          last_cyc    = cyc;
        end
      end
      if (spectrum_valid) begin
        check("valid_latency", cyc - last_cyc, 9);
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          last_pub = exp_q.pop_front();
          check("packed_word", spectrum_data_packed, last_pub);
        end
      end else begin
        check("packed_hold", spectrum_data_packed, last_pub);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_beat(input int data, input bit last);
    bit ok;
    mag_valid = 1'b1;
    mag_data  = 16'(data);
    mag_last  = last;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      ok = mag_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mag_valid = 1'b0;
      mag_last  = 1'b0;
      mag_data  = 16'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int len, input bit gaps, input bit publish, input bit keep);
    int pk [8];
    int s;
    int b;
    logic [95:0] w;
    pk = '{default: 0};
    w  = '0;
    for (int i = 1; i < len && i < N_BINS; i++) begin
      b = band_of(i);
      if (frame_bins[i] > pk[b]) pk[b] = frame_bins[i];
    end
    for (int k = 0; k < 8; k++) begin
      s = pk[k] / 16;
      if (s > 4095) s = 4095;
`ifdef PEAK_HOLD_EN
      begin
        int dec;
        dec = (held_m[k] > 64) ? held_m[k] - 64 : 0;
        if (dec > s) s = dec;
        if (publish) held_m[k] = s;
      end
`endif
      w[k*12 +: 12] = 12'(s);
    end
    if (publish) exp_q.push_back(w);
    len_q.push_back(len);
    if (len > N_BINS) ovr_exp += len - N_BINS;
    for (int i = 0; i < len; i++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      send_beat(frame_bins[i], i == len - 1);
    end
    if (!keep) begin
      mag_valid = 1'b0;
      mag_last  = 1'b0;
    end
  endtask

  task automatic wait_pub();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
    check("publish_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bins();
    for (int i = 0; i < 128; i++) frame_bins[i] = 0;
  endtask

  task automatic random_bins(input int len);
    for (int i = 0; i < len; i++) frame_bins[i] = rand_mag();
  endtask

  logic [95:0] exp_w;
  int          ovr0;

  initial begin
    rst_n     = 1'b1;
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    mag_data  = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", mag_ready, 1);
    check("rst_valid", spectrum_valid, 0);
    check("rst_overrun", frame_overrun, 0);
    check("rst_packed", spectrum_data_packed, '0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single bin in band 3.
    clear_bins();
    frame_bins[5] = 16'h0400;
    drive_frame(64, 1'b0, 1'b1, 1'b0);
    wait_pub();
    exp_w = 96'h040 << 36;
    check("bin5_band3", spectrum_data_packed, exp_w);

    // Saturation on band 7, DC ignored.
    clear_bins();
    frame_bins[0]  = 16'hFFFF;
    frame_bins[40] = 16'hFFFF;
    drive_frame(64, 1'b1, 1'b1, 1'b0);
    wait_pub();
    check("band7_sat", spectrum_data_packed[95:84], 12'hFFF);
    check("band0_dc", spectrum_data_packed[11:0], 12'h000);

    // Random short/full frames with gaps.
    for (int f = 0; f < 5; f++) begin
      clear_bins();
      random_bins(int'($urandom_range(1, 64)));
      drive_frame(int'($urandom_range(1, 64)), 1'b1, 1'b1, 1'b0);
      wait_pub();
    end

    // Back-to-back frames with mag_valid held through the finalize gap.
    clear_bins();
    random_bins(64);
    drive_frame(64, 1'b0, 1'b1, 1'b1);
    clear_bins();
    random_bins(40);
    drive_frame(40, 1'b0, 1'b1, 1'b0);
    wait_pub();

    // Overrun: 70 beats, last on the 70th.
    clear_bins();
    random_bins(70);
    ovr0 = ovr_cnt;
    drive_frame(70, 1'b0, 1'b1, 1'b0);
    wait_pub();
    check("overrun_pulses", ovr_cnt - ovr0, 6);

    // mag_last on bin 0.
    clear_bins();
    frame_bins[0] = 16'hFFFF;
    drive_frame(1, 1'b0, 1'b1, 1'b0);
    wait_pub();

    // Reset during FINALIZE band 4: no strobe, outputs cleared.
    clear_bins();
    random_bins(64);
    drive_frame(64, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_packed", spectrum_data_packed, '0);
    check("midrst_valid", spectrum_valid, 0);
    check("midrst_ready", mag_ready, 1);
`ifdef PEAK_HOLD_EN
    held_m = '{default: 0};
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Fresh frames after reset; also exercises peak hold and decay.
    clear_bins();
    frame_bins[3] = 16'h8000;
    drive_frame(64, 1'b0, 1'b1, 1'b0);
    wait_pub();
    exp_w = 96'h800 << 24;
    check("postrst_frame1", spectrum_data_packed, exp_w);
    clear_bins();
    drive_frame(64, 1'b1, 1'b1, 1'b0);
    wait_pub();
`ifdef PEAK_HOLD_EN
    check("hold_frame2_band2", spectrum_data_packed[35:24], 12'h7C0);
`else
    check("hold_frame2_band2", spectrum_data_packed[35:24], 12'h000);
`endif
    drive_frame(64, 1'b0, 1'b1, 1'b0);
    wait_pub();
`ifdef PEAK_HOLD_EN
    check("hold_frame3_band2", spectrum_data_packed[35:24], 12'h780);
`else
    check("hold_frame3_band2", spectrum_data_packed[35:24], 12'h000);
`endif

    idle(20);
    check("overrun_total", ovr_cnt, ovr_exp);
    check("exp_drained", exp_q.size(), 0);
    check("len_drained", len_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_band_aggregator.md
Name: spectrum_band_aggregator

Overview:
Collects one frame of FFT magnitude bins, streamed one bin per accepted beat, and reduces it to 8 display bands of 12 bits each. Applies per-band peak detection, scaling with saturation, and optional peak-hold with decay. Publishes the result as a 96-bit packed word with a one-cycle valid strobe. Sits directly upstream of the 74HC595 seven-segment display driver and feeds its spectrum_data_packed / spectrum_valid inputs.

Parameters:
N_BINS, 64, bins per frame (bin 0 = DC, always discarded)
MAG_W, 16, input magnitude width
MAG_SHIFT, 4, right shift applied to a band peak before saturation to 12 bits
DECAY, 12'd64, per-frame decrement of held peak (peak-hold build only)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
mag_data  in  MAG_W  unsigned magnitude of current bin
mag_valid  in  1  mag_data/mag_last valid
mag_last  in  1  final bin of frame, qualified by mag_valid
mag_ready  out  1  block accepts a beat when mag_valid && mag_ready
spectrum_data_packed  out  96  band k in bits [12k+11:12k], k=0..7
spectrum_valid  out  1  one-cycle strobe, packed data updated this cycle
frame_overrun  out  1  one-cycle pulse, bin index >= N_BINS received

Behaviour:
- Reset values: mag_ready=1, spectrum_data_packed=0, spectrum_valid=0, frame_overrun=0, bin counter=0, all band peaks and held values 0, state=ACCUM.
- Bin index is implicit: the counter starts at 0 per frame and increments on each accepted beat. It saturates at N_BINS and clears after mag_last.
- Band map, inclusive bin ranges: b0 1, b1 2, b2 3-4, b3 5-8, b4 9-12, b5 13-20, b6 21-36, b7 37-63.
  - Bin 0 is ignored.
  - Bins >= N_BINS are ignored and pulse frame_overrun on the cycle after acceptance.
- States:
  - ACCUM: mag_ready=1. Each accepted bin updates peak[band] = max(peak[band], mag_data).
  - An accepted beat with mag_last=1 is still accumulated. The state then moves to FINALIZE, with mag_ready dropping on the next cycle.
  - FINALIZE: mag_ready=0. Runs 8 cycles, one band per cycle, k=0..7.
    - scaled = peak[k] >> MAG_SHIFT.
    - If scaled > 4095, scaled = 4095.
    - The result is written to the output slot k, and peak[k] is cleared to 0.
  - PUBLISH: mag_ready=0 for 1 cycle. spectrum_valid=1 and the packed word is stable. The state then returns to ACCUM with mag_ready=1.
- Latency: mag_last accepted at cycle T gives spectrum_valid high at T+9, and mag_ready high again at T+10.
- Packed output changes only during FINALIZE/PUBLISH and holds otherwise.
- Slot update inside FINALIZE: the packed output register is built internally and transferred whole at PUBLISH. Downstream never sees a partially updated word.
- A short frame (mag_last before bin N_BINS-1) finalizes normally. Unvisited bands output 0, or decayed hold in the peak-hold build.
- mag_last on bin 0 produces an all-zero (or decayed) frame.
- Reset mid-FINALIZE returns to reset values immediately. No strobe is issued.
- mag_valid held high while mag_ready=0 is not consumed. Data must be held by the source (standard valid/ready).

Optional Feature:
- Macro PEAK_HOLD_EN.
- Defined:
  - Per band, held[k] holds its value between frames.
  - In FINALIZE: dec = (held[k] > DECAY) ? held[k]-DECAY : 0, then out = max(scaled, dec), and held[k] = out.
- Undefined: out = scaled. No held registers are present and DECAY is unused.

Decomposition:
- Package spectrum_pkg holds:
  - N_BANDS=8 and BAND_W=12.
  - The BAND_HI constant array {1,2,4,8,12,20,36,63}.
  - The band-index function bin_to_band(bin) returning 3 bits plus a valid flag (false for bin 0 or bin > 63).
  - The 96-bit packed typedef shared with the display driver.
- Sub-module band_scaler (combinational): scale, saturate, and decay/max for one band. It is instantiated once and time-multiplexed across FINALIZE cycles.

Test Plan:
- Single frame with bin 5 = 16'h0400 and all others 0:
  - band3 = 12'h040, all other bands 0.
  - spectrum_valid pulses exactly 9 cycles after the mag_last beat.
- Bin 40 = 16'hFFFF: band7 saturates to 12'hFFF and does not wrap. Bin 0 = 16'hFFFF is ignored and band0 stays 0.
- Backpressure: mag_valid held high continuously across two frames. mag_ready is low for 9 cycles after each mag_last, and no bin is lost or duplicated (check by a per-bin counter).
- 70 bins with no mag_last, then mag_last:
  - frame_overrun pulses 6 times.
  - Bands reflect bins 1-63 only.
- PEAK_HOLD_EN: frame1 gives band2 = 12'h800, then frame2 is all zeros. Frame2 band2 = 12'h7C0, frame3 = 12'h780. Without the macro, frame2 band2 = 0.
- Assert rst_n low during FINALIZE cycle 4:
  - outputs go to 0 asynchronously and there is no spectrum_valid.
  - The next full frame produces correct values with no stale peaks.
